pip_mem_wb: RTL
===============

Name: pip_mem_wb

Overview:
- MEM-stage read side and MEM/WB pipeline register. Consumes the EX/MEM register outputs and issues load requests to data memory.
- Waits on a variable-latency read response, stalling upstream stages while the load is outstanding.
- Sign/zero-extends and aligns load data, then registers the writeback triple (data, rd, enable) for the register file and forwarding logic.

Parameters:
- MAX_WAIT, 15, maximum cycles to wait for dmem_rvalid before abandoning a load (1..255).
- CW, 8, width of the wait counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- alu_out_p  in  32  ALU result from EX/MEM
- dmem_addr_p  in  32  data memory byte address from EX/MEM
- dmem_ctrl_p  in  3  access type, funct3 encoding: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- rd_p  in  5  destination register
- rdEn_p  in  1  instruction writes rd
- DMwriteEn_p  in  1  store; never writes back
- mem_rd_p  in  1  instruction is a load
- dmem_rdata  in  32  word read data, word-aligned
- dmem_rvalid  in  1  read data valid
- dmem_req  out  1  read request, combinational
- dmem_raddr  out  32  word address, {dmem_addr_p[31:2],2'b00}
- stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM
- wb_data  out  32  registered writeback data
- wb_rd  out  5  registered destination
- wb_en  out  1  registered writeback enable
- misalign  out  1  registered one-cycle pulse on a misaligned load
- timeout_err  out  1  sticky flag, cleared only by rst

Behaviour:
- Reset: synchronous, active-high. FSM goes to IDLE, counter to 0. wb_data=0, wb_rd=0, wb_en=0, misalign=0, timeout_err=0.
- FSM states: IDLE, WAIT.
- Load accepted: in IDLE with mem_rd_p=1, rdEn_p=1 and an aligned address.
  - dmem_req=1.
  - If dmem_rvalid=1 in the same cycle: stall=0, data is formatted and registered at the next edge, and the FSM stays in IDLE. Latency is 1.
  - Else: stall=1 and next state is WAIT.
- WAIT:
  - dmem_req=1 and stall=1; counter increments every cycle.
  - Inputs are held by upstream because of stall.
  - dmem_rvalid=1: stall=0 combinationally, data registered at the edge, counter cleared, next state IDLE.
  - Counter reaches MAX_WAIT with no rvalid: stall=0, wb_en=0 at the edge, timeout_err<=1, next state IDLE.
- Formatting (byte lane b = dmem_addr_p[1:0]):
  - LB/LBU: byte b, sign- or zero-extended.
  - LH/LHU: halfword b[1], sign- or zero-extended.
  - LW: full word.
  - Reserved ctrl codes (011, 11x): treated as LW.
- Misaligned load (LH/LHU with addr[0]=1, or LW with addr[1:0]!=0):
  - No dmem_req, no stall.
  - At the next edge: wb_en=0, misalign=1 for exactly one cycle.
- Non-load with rdEn_p=1: wb_data<=alu_out_p, wb_en<=1, stall=0.
- Store (DMwriteEn_p=1): wb_en<=0. A store with mem_rd_p=1 is treated as a store.
- rd_p=0: wb_en<=0 regardless of instruction; writes to x0 are suppressed here.
- While stall=1: the MEM/WB register loads a bubble (wb_en<=0). wb_rd and wb_data hold their previous values.
- Reset mid-WAIT: FSM returns to IDLE, stall deasserts the next cycle, and a late dmem_rvalid is ignored in IDLE unless a new load is present.
- dmem_rvalid while in IDLE with no load: ignored.

Decomposition:
- Shared package pip_pkg:
  - funct3 load codes (LB_F3, LH_F3, LW_F3, LBU_F3, LHU_F3).
  - FSM state typedef (MEM_IDLE, MEM_WAIT).
- One sub-module, load_align: combinational byte/halfword select and extend. Inputs are rdata, addr[1:0] and ctrl; outputs are the 32-bit result and the misalign flag. The top-level block holds the FSM, counter and register.

Test Plan:
- ALU op: rdEn_p=1, rd_p=5, alu_out_p=0x0000_1234 -> next cycle wb_en=1, wb_rd=5, wb_data=0x0000_1234, stall=0 throughout.
- LB zero-latency: addr=0x103, ctrl=000, rdata=0x80AA_BBCC, rvalid same cycle -> wb_data=0xFFFF_FF80, wb_en=1, stall never high.
- LHU with 3-cycle memory delay: addr=0x102, rdata=0x9ABC_0000 -> stall high 3 cycles, then wb_data=0x0000_9ABC, wb_en=1 one cycle later, counter back to 0.
- Misaligned LW: addr=0x101 -> dmem_req=0, misalign pulses 1 cycle, wb_en=0, timeout_err=0.
- Timeout: load issued, rvalid never asserted -> stall high exactly MAX_WAIT=15 cycles, then timeout_err=1 and stays 1, wb_en=0. A subsequent ALU op writes back normally.
- Reset in WAIT: assert rst at cycle 2 of a wait -> next cycle FSM IDLE, stall=0, all outputs at reset values. A late rvalid causes no writeback. Store with rd_p=7 produces wb_en=0.

Source files
------------

// File: rtl/pip_pkg.sv
// Shared definitions for the MEM/WB slice: load funct3 codes and MEM-stage FSM states.
// No logic; imported by load_align and pip_mem_wb.
// Reserved funct3 values (011, 11x) have no name here and fall through to word handling.
package pip_pkg;

    localparam logic [2:0] LB_F3  = 3'b000;
    localparam logic [2:0] LH_F3  = 3'b001;
    localparam logic [2:0] LW_F3  = 3'b010;
    localparam logic [2:0] LBU_F3 = 3'b100;
    localparam logic [2:0] LHU_F3 = 3'b101;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/load_align.sv
// Byte/halfword lane select with sign or zero extension for loads, plus misalignment detect.
// Latency: purely combinational.
// Backpressure: none; the result is consumed by the MEM/WB register in the same cycle.
module load_align
    import pip_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  ctrl,
    output logic [31:0] result,
    output logic        misalign
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        shifted  = rdata >> {addr, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        result   = rdata;
        misalign = 1'b0;
        case (ctrl)
            LB_F3: begin
                result = {{24{byte_sel[7]}}, byte_sel};
            end
            LBU_F3: begin
                result = {24'h0, byte_sel};
            end
            LH_F3: begin
                result   = {{16{half_sel[15]}}, half_sel};
                misalign = addr[0];
            end
            LHU_F3: begin
                result   = {16'h0, half_sel};
                misalign = addr[0];
            end
            LW_F3: begin
                result   = rdata;
                misalign = |addr;
            end
            default: begin
                result   = rdata;
                misalign = |addr;
            end
        endcase
    end

endmodule

// File: rtl/pip_mem_wb.sv
// MEM-stage load issue/wait FSM and MEM/WB register producing the writeback triple.
// Latency: 1 cycle to wb_* for ALU ops and zero-wait loads; loads add the memory wait.
// Backpressure: stall held high while a load is outstanding, up to MAX_WAIT cycles.
module pip_mem_wb
    import pip_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int CW       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_out_p,
    input  logic [31:0] dmem_addr_p,
    input  logic [2:0]  dmem_ctrl_p,
    input  logic [4:0]  rd_p,
    input  logic        rdEn_p,
    input  logic        DMwriteEn_p,
    input  logic        mem_rd_p,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_rvalid,
    output logic        dmem_req,
    output logic [31:0] dmem_raddr,
    output logic        stall,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_en,
    output logic        misalign,
    output logic        timeout_err
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    mem_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_en_q, wb_en_d;
    logic        misalign_q, misalign_d;
    logic        timeout_err_q, timeout_err_d;

    logic        stall_c;
    logic        req_c;
    logic        is_load;
    logic        rd_nz;
    logic [31:0] la_result;
    logic        la_mis;

    load_align u_load_align (
        .rdata    (dmem_rdata),
        .addr     (dmem_addr_p[1:0]),
        .ctrl     (dmem_ctrl_p),
        .result   (la_result),
        .misalign (la_mis)
    );

    // A store that also claims mem_rd is a store: it never reads or writes back.
    assign is_load = mem_rd_p & ~DMwriteEn_p;
    assign rd_nz   = |rd_p;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wb_en_d       = 1'b0;
        wb_data_d     = wb_data_q;
        wb_rd_d       = wb_rd_q;
        misalign_d    = 1'b0;
        timeout_err_d = timeout_err_q;
        stall_c       = 1'b0;
        req_c         = 1'b0;

        case (state_q)
            MEM_IDLE: begin
                if (is_load) begin
                    if (la_mis) begin
                        misalign_d = 1'b1;
                    end else if (rdEn_p) begin
                        req_c = 1'b1;
                        if (dmem_rvalid) begin
                            wb_en_d = rd_nz;
                        end else begin
                            stall_c = 1'b1;
                            state_d = MEM_WAIT;
                            cnt_d   = CW'(1);
                        end
                    end
                end else begin
                    wb_en_d = rdEn_p & rd_nz & ~DMwriteEn_p;
                end
            end
            MEM_WAIT: begin
                req_c = 1'b1;
                if (dmem_rvalid) begin
                    wb_en_d = rd_nz;
                    state_d = MEM_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= MAX_CNT) begin
                    // Abandon the load: release the pipeline with a bubble.
                    timeout_err_d = 1'b1;
                    state_d       = MEM_IDLE;
                    cnt_d         = '0;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = MEM_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (wb_en_d) begin
            wb_data_d = is_load ? la_result : alu_out_p;
            wb_rd_d   = rd_p;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= MEM_IDLE;
            cnt_q         <= '0;
            wb_data_q     <= '0;
            wb_rd_q       <= '0;
            wb_en_q       <= 1'b0;
            misalign_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wb_data_q     <= wb_data_d;
            wb_rd_q       <= wb_rd_d;
            wb_en_q       <= wb_en_d;
            misalign_q    <= misalign_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign dmem_req    = req_c;
    assign dmem_raddr  = {dmem_addr_p[31:2], 2'b00};
    assign stall       = stall_c;
    assign wb_data     = wb_data_q;
    assign wb_rd       = wb_rd_q;
    assign wb_en       = wb_en_q;
    assign misalign    = misalign_q;
    assign timeout_err = timeout_err_q;

endmodule
